// File: rtl/avmm_if.sv
// Avalon-MM bus bundle; the master modport drives the command side and the
// slave modport drives waitrequest and the read response.
interface avmm_if #(
  parameter int AW = 16,
  parameter int DW = 32,
  parameter int BW = 4
);
  logic [AW-1:0]   address;
  logic [DW-1:0]   writedata;
  logic [DW/8-1:0] byteenable;
  logic [BW-1:0]   burstcount;
  logic            read;
  logic            write;
  logic            waitrequest;
  logic [DW-1:0]   readdata;
  logic            readdatavalid;

  modport master (
    output address, writedata, byteenable, burstcount, read, write,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, writedata, byteenable, burstcount, read, write,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/avmm_rr_arbiter_m.sv
// Round-robin arbiter sharing one Avalon-MM slave between N masters: holds the
// grant for write bursts and routes read responses back through an ID FIFO.
module avmm_rr_arbiter_m #(
  parameter int N        = 2,
  parameter int AW       = 16,
  parameter int DW       = 32,
  parameter int BW       = 4,
  parameter int MAX_PEND = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  avmm_if.slave                     m [N],
  avmm_if.master                    s,
  output logic [N-1:0]              grant,
  output logic [$clog2(MAX_PEND):0] pend,
  output logic                      err
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = $clog2(MAX_PEND);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // A burstcount of zero still moves one beat.
  function automatic logic [BW-1:0] bc_norm(input logic [BW-1:0] bc);
    return (bc == '0) ? BW'(1'b1) : bc;
  endfunction

  function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] req,
                                            input logic [IW-1:0] ptr);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx   = (int'(ptr) + k) % N;
      pick  = (!found && req[idx]) ? IW'(idx) : pick;
      found = found | req[idx];
    end
    return pick;
  endfunction

  // Master-side buses flattened so the granted one can be selected by index.
  logic [N-1:0]    m_rd_s;
  logic [N-1:0]    m_wr_s;
  logic [AW-1:0]   m_addr_s  [N];
  logic [DW-1:0]   m_wdata_s [N];
  logic [DW/8-1:0] m_be_s    [N];
  logic [BW-1:0]   m_bc_s    [N];
  logic [N-1:0]    m_wait_s;
  logic [N-1:0]    m_rdv_s;

  for (genvar i = 0; i < N; i++) begin : g_master
    assign m_rd_s[i]          = m[i].read;
    assign m_wr_s[i]          = m[i].write;
    assign m_addr_s[i]        = m[i].address;
    assign m_wdata_s[i]       = m[i].writedata;
    assign m_be_s[i]          = m[i].byteenable;
    assign m_bc_s[i]          = m[i].burstcount;
    assign m[i].waitrequest   = m_wait_s[i];
    assign m[i].readdatavalid = m_rdv_s[i];
    assign m[i].readdata      = s.readdata;
  end

  state_t        state_r;
  logic [N-1:0]  grant_r;
  logic [IW-1:0] gidx_r;
  logic [IW-1:0] prio_r;
  logic          burst_r;
  logic [BW-1:0] beats_r;

  logic [IW-1:0] id_q  [MAX_PEND];
  logic [BW-1:0] cnt_q [MAX_PEND];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] cnt_r;
  logic          err_r;

  logic          g_rd_s;
  logic          g_wr_s;
  logic [BW-1:0] g_bc_s;
  logic          g_wait_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          s_rd_s;
  logic          s_wr_s;
  logic          rd_acc_s;
  logic          wr_acc_s;
  logic          wr_last_s;
  logic          rdv_ok_s;
  logic          push_s;
  logic          pop_s;
  logic [IW-1:0] head_id_s;
  logic [BW-1:0] head_cnt_s;
  logic [IW-1:0] pick_s;
  logic [IW-1:0] next_prio_s;

  // Command path, accept decode and response routing.
  always_comb begin
    g_rd_s       = m_rd_s[gidx_r];
    g_wr_s       = m_wr_s[gidx_r];
    g_bc_s       = bc_norm(m_bc_s[gidx_r]);
    fifo_full_s  = (cnt_r == CW'(MAX_PEND));
    fifo_empty_s = (cnt_r == '0);
    if (state_r == ST_GRANT) begin
      s_wr_s = g_wr_s;
      s_rd_s = g_rd_s & ~g_wr_s & ~fifo_full_s;
    end else begin
      s_wr_s = 1'b0;
      s_rd_s = 1'b0;
    end
    // A read blocked by a full ID FIFO is stalled here, not by the slave.
    g_wait_s  = (g_rd_s & ~g_wr_s & fifo_full_s) ? 1'b1 : s.waitrequest;
    rd_acc_s  = s_rd_s & ~s.waitrequest;
    wr_acc_s  = s_wr_s & ~s.waitrequest;
    wr_last_s = burst_r ? (beats_r == BW'(1'b1)) : (g_bc_s == BW'(1'b1));

    head_id_s  = id_q[rd_ptr_r];
    head_cnt_s = cnt_q[rd_ptr_r];
    rdv_ok_s   = s.readdatavalid & ~fifo_empty_s;
    push_s     = rd_acc_s;
    pop_s      = rdv_ok_s & (head_cnt_s == BW'(1'b1));

    for (int i = 0; i < N; i++) begin
      m_wait_s[i] = grant_r[i] ? g_wait_s : 1'b1;
      m_rdv_s[i]  = rdv_ok_s & (head_id_s == IW'(i));
    end

    pick_s      = rr_pick(m_rd_s | m_wr_s, prio_r);
    next_prio_s = (gidx_r == IW'(N - 1)) ? '0 : gidx_r + IW'(1'b1);
  end

  assign s.address    = m_addr_s[gidx_r];
  assign s.writedata  = m_wdata_s[gidx_r];
  assign s.byteenable = m_be_s[gidx_r];
  assign s.burstcount = m_bc_s[gidx_r];
  assign s.read       = s_rd_s;
  assign s.write      = s_wr_s;

  assign grant = grant_r;
  assign pend  = cnt_r;
  assign err   = err_r;

  // Arbitration FSM with write-burst grant hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      grant_r <= '0;
      gidx_r  <= '0;
      prio_r  <= '0;
      burst_r <= 1'b0;
      beats_r <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (|(m_rd_s | m_wr_s)) begin
            gidx_r  <= pick_s;
            grant_r <= N'(1'b1) << pick_s;
            state_r <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (wr_acc_s) begin
            if (wr_last_s) begin
              state_r <= ST_IDLE;
              grant_r <= '0;
              prio_r  <= next_prio_s;
              burst_r <= 1'b0;
            end else if (burst_r) begin
              beats_r <= beats_r - BW'(1'b1);
            end else begin
              burst_r <= 1'b1;
              beats_r <= g_bc_s - BW'(1'b1);
            end
          end else if (rd_acc_s) begin
            state_r <= ST_IDLE;
            grant_r <= '0;
            prio_r  <= next_prio_s;
          end else if (!burst_r && !g_rd_s && !g_wr_s) begin
            // Request withdrawn before acceptance: priority stays put.
            state_r <= ST_IDLE;
            grant_r <= '0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          grant_r <= '0;
          burst_r <= 1'b0;
        end
      endcase
    end
  end

  // Outstanding-read ID FIFO and the sticky orphan-response flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < MAX_PEND; k++) begin
        id_q[k]  <= '0;
        cnt_q[k] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      if (push_s) begin
        id_q[wr_ptr_r]  <= gidx_r;
        cnt_q[wr_ptr_r] <= g_bc_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end else if (rdv_ok_s) begin
        cnt_q[rd_ptr_r] <= head_cnt_s - BW'(1'b1);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1'b1);
        2'b01:   cnt_r <= cnt_r - CW'(1'b1);
        default: cnt_r <= cnt_r;
      endcase
      if (s.readdatavalid && fifo_empty_s) begin
        err_r <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_avmm_rr_arbiter_m.sv
// Scoreboard bench for avmm_rr_arbiter_m: expected slave-side writes and
// master-side read beats are queued at issue and checked as they appear.
module tb_avmm_rr_arbiter_m;
  localparam int N        = 2;
  localparam int AW       = 16;
  localparam int DW       = 32;
  localparam int BW       = 4;
  localparam int MAX_PEND = 4;
  localparam int CW       = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  avmm_if #(.AW(AW), .DW(DW), .BW(BW)) m_if [N] ();
  avmm_if #(.AW(AW), .DW(DW), .BW(BW)) s_if ();

  logic [N-1:0]  grant;
  logic [CW-1:0] pend;
  logic          err;

  logic [N-1:0]  tb_rd, tb_wr, tb_wait, tb_rdv;
  logic [AW-1:0] tb_addr  [N];
  logic [DW-1:0] tb_wdata [N];
  logic [BW-1:0] tb_bc    [N];
  logic [DW-1:0] tb_rdata [N];
  logic          sl_wait, sl_rdv;
  logic [DW-1:0] sl_rdata;

  for (genvar i = 0; i < N; i++) begin : g_m
    assign m_if[i].read       = tb_rd[i];
    assign m_if[i].write      = tb_wr[i];
    assign m_if[i].address    = tb_addr[i];
    assign m_if[i].writedata  = tb_wdata[i];
    assign m_if[i].burstcount = tb_bc[i];
    assign m_if[i].byteenable = 4'hF;
    assign tb_wait[i]         = m_if[i].waitrequest;
    assign tb_rdv[i]          = m_if[i].readdatavalid;
    assign tb_rdata[i]        = m_if[i].readdata;
  end
  assign s_if.waitrequest   = sl_wait;
  assign s_if.readdata      = sl_rdata;
  assign s_if.readdatavalid = sl_rdv;

  avmm_rr_arbiter_m #(.N(N), .AW(AW), .DW(DW), .BW(BW), .MAX_PEND(MAX_PEND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m     (m_if),
    .s     (s_if),
    .grant (grant),
    .pend  (pend),
    .err   (err)
  );

  typedef struct {
    logic [N-1:0]  gnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] bc;
  } wexp_t;

  typedef struct {
    int            id;
    logic [DW-1:0] data;
  } rexp_t;

  wexp_t         wq[$];
  rexp_t         rq[$];
  int            checks = 0;
  int            passed = 0;
  int            rdv_cnt [N];
  logic [DW-1:0] rd_seq  = 32'h5000_0000;
  logic [DW-1:0] exp_seq = 32'h5000_0000;

  task automatic push_w(input logic [N-1:0] g, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] bc);
    wexp_t e;
    e.gnt = g; e.addr = a; e.data = d; e.bc = bc;
    wq.push_back(e);
  endtask

  task automatic push_r(input int id, input int beats);
    rexp_t e;
    for (int k = 0; k < beats; k++) begin
      e.id = id; e.data = exp_seq;
      exp_seq = exp_seq + 32'd1;
      rq.push_back(e);
    end
  endtask

  task automatic monitor_loop();
    wexp_t we;
    rexp_t re;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (s_if.write === 1'b1 && sl_wait === 1'b0) begin
          checks++;
          if (wq.size() == 0) begin
            $display("FAIL wr_unexpected addr=%h data=%h", s_if.address, s_if.writedata);
          end else begin
            we = wq.pop_front();
            if (grant !== we.gnt || s_if.address !== we.addr || s_if.writedata !== we.data ||
                s_if.burstcount !== we.bc || s_if.byteenable !== 4'hF)
              $display("FAIL wr_beat got gnt=%b addr=%h data=%h bc=%0d exp gnt=%b addr=%h data=%h bc=%0d",
                       grant, s_if.address, s_if.writedata, s_if.burstcount,
                       we.gnt, we.addr, we.data, we.bc);
            else passed++;
          end
        end
        for (int i = 0; i < N; i++) begin
          if (tb_rdv[i] === 1'b1) begin
            checks++;
            rdv_cnt[i]++;
            if (rq.size() == 0) begin
              $display("FAIL rdv_unexpected master=%0d data=%h", i, tb_rdata[i]);
            end else begin
              re = rq.pop_front();
              if (re.id != i || tb_rdata[i] !== re.data)
                $display("FAIL rdv_route got master=%0d data=%h exp master=%0d data=%h",
                         i, tb_rdata[i], re.id, re.data);
              else passed++;
            end
          end
        end
      end
    end
  endtask

  // One command (a read, or a write of bc beats) from master i, bounded wait per beat.
  task automatic do_cmd(input int i, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [BW-1:0] bc);
    int beats;
    bit acc;
    beats = (wr && bc > 4'd1) ? int'(bc) : 1;
    for (int b = 0; b < beats; b++) begin
      tb_addr[i] = a; tb_wdata[i] = d + DW'(b); tb_bc[i] = bc;
      tb_wr[i] = wr; tb_rd[i] = !wr;
      acc = 1'b0;
      for (int t = 0; t < 200 && !acc; t++) begin
        @(negedge clk);
        if (tb_wait[i] === 1'b0) acc = 1'b1;
        else @(posedge clk);
      end
      @(posedge clk); #1;
      checks++;
      if (!acc) begin
        $display("FAIL cmd_accept master=%0d beat=%0d got=timeout exp=accepted", i, b);
        b = beats;
      end else passed++;
    end
    tb_rd[i] = 1'b0; tb_wr[i] = 1'b0;
  endtask

  task automatic respond(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      sl_rdv = 1'b1; sl_rdata = rd_seq;
      rd_seq = rd_seq + 32'd1;
    end
    @(posedge clk); #1;
    sl_rdv = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tb_rd = '0; tb_wr = '0; sl_wait = 1'b0; sl_rdv = 1'b0; sl_rdata = '0;
    for (int i = 0; i < N; i++) begin
      tb_addr[i] = '0; tb_wdata[i] = '0; tb_bc[i] = '0; rdv_cnt[i] = 0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (grant !== 2'b00) $display("FAIL rst_grant got=%b exp=00", grant); else passed++;
    checks++; if (pend !== 3'd0) $display("FAIL rst_pend got=%0d exp=0", pend); else passed++;
    checks++; if (err !== 1'b0) $display("FAIL rst_err got=%b exp=0", err); else passed++;
    checks++; if ({s_if.read, s_if.write} !== 2'b00)
      $display("FAIL rst_s_cmd got=%b exp=00", {s_if.read, s_if.write}); else passed++;
    checks++; if (tb_wait !== 2'b11) $display("FAIL rst_wait got=%b exp=11", tb_wait); else passed++;
    checks++; if (tb_rdv !== 2'b00) $display("FAIL rst_rdv got=%b exp=00", tb_rdv); else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_simultaneous_writes();
    push_w(2'b01, 16'h0010, 32'hA000_0001, 4'd1);
    push_w(2'b10, 16'h0020, 32'hB000_0001, 4'd1);
    fork
      do_cmd(0, 1'b1, 16'h0010, 32'hA000_0001, 4'd1);
      do_cmd(1, 1'b1, 16'h0020, 32'hB000_0001, 4'd1);
      begin
        logic [N-1:0] exp_g [4];
        exp_g[0] = 2'b00; exp_g[1] = 2'b01; exp_g[2] = 2'b00; exp_g[3] = 2'b10;
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          checks++;
          if (grant !== exp_g[k]) $display("FAIL sim_grant_seq cyc=%0d got=%b exp=%b", k, grant, exp_g[k]);
          else passed++;
        end
      end
    join
  endtask

  task automatic test_write_burst();
    for (int b = 0; b < 4; b++) push_w(2'b01, 16'h0100, 32'hC000_0000 + DW'(b), 4'd4);
    push_w(2'b10, 16'h0200, 32'hD000_0000, 4'd1);
    fork
      do_cmd(0, 1'b1, 16'h0100, 32'hC000_0000, 4'd4);
      begin
        @(posedge clk); #1;
        do_cmd(1, 1'b1, 16'h0200, 32'hD000_0000, 4'd1);
      end
      begin
        repeat (2) @(posedge clk);
        #1 sl_wait = 1'b1;
        @(negedge clk);
        checks++;
        if (grant !== 2'b01 || tb_wait !== 2'b11)
          $display("FAIL burst_hold got grant=%b wait=%b exp grant=01 wait=11", grant, tb_wait);
        else passed++;
        repeat (2) @(posedge clk);
        #1 sl_wait = 1'b0;
      end
    join
  endtask

  task automatic test_read_routing();
    int c0, c1;
    c0 = rdv_cnt[0]; c1 = rdv_cnt[1];
    push_r(0, 2);
    push_r(1, 1);
    do_cmd(0, 1'b0, 16'h0300, '0, 4'd2);
    do_cmd(1, 1'b0, 16'h0400, '0, 4'd1);
    @(negedge clk);
    checks++; if (pend !== 3'd2) $display("FAIL rd_pend_issued got=%0d exp=2", pend); else passed++;
    respond(3);
    @(negedge clk);
    checks++; if (pend !== 3'd0) $display("FAIL rd_pend_drained got=%0d exp=0", pend); else passed++;
    checks++;
    if (rdv_cnt[0] - c0 != 2 || rdv_cnt[1] - c1 != 1)
      $display("FAIL rd_beat_counts got m0=%0d m1=%0d exp m0=2 m1=1", rdv_cnt[0] - c0, rdv_cnt[1] - c1);
    else passed++;
  endtask

  task automatic test_fifo_full();
    push_r(0, 5);
    for (int k = 0; k < 4; k++) do_cmd(0, 1'b0, 16'h0500 + AW'(k), '0, 4'd1);
    fork
      do_cmd(0, 1'b0, 16'h0504, '0, 4'd1);
      begin
        repeat (4) @(negedge clk);
        checks++;
        if (tb_wait[0] !== 1'b1 || pend !== 3'd4 || s_if.read !== 1'b0)
          $display("FAIL full_hold got wait=%b pend=%0d sread=%b exp wait=1 pend=4 sread=0",
                   tb_wait[0], pend, s_if.read);
        else passed++;
        respond(1);
      end
    join
    @(negedge clk);
    checks++; if (pend !== 3'd4) $display("FAIL full_refill got=%0d exp=4", pend); else passed++;
    respond(4);
    @(negedge clk);
    checks++; if (pend !== 3'd0) $display("FAIL full_drain got=%0d exp=0", pend); else passed++;
  endtask

  task automatic test_spurious_rdv();
    @(negedge clk);
    checks++; if (err !== 1'b0) $display("FAIL spur_err_before got=%b exp=0", err); else passed++;
    @(posedge clk); #1;
    sl_rdv = 1'b1; sl_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (tb_rdv !== 2'b00) $display("FAIL spur_rdv got=%b exp=00", tb_rdv); else passed++;
    @(posedge clk); #1;
    sl_rdv = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (err !== 1'b1) $display("FAIL spur_err_sticky got=%b exp=1", err); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (err !== 1'b0) $display("FAIL spur_err_reset got=%b exp=0", err); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    bit acc;
    push_r(0, 2);
    do_cmd(0, 1'b0, 16'h0700, '0, 4'd1);
    do_cmd(0, 1'b0, 16'h0701, '0, 4'd1);
    @(negedge clk);
    checks++; if (pend !== 3'd2) $display("FAIL mid_pend_before got=%0d exp=2", pend); else passed++;
    push_w(2'b10, 16'h0800, 32'hE000_0000, 4'd4);
    tb_addr[1] = 16'h0800; tb_wdata[1] = 32'hE000_0000; tb_bc[1] = 4'd4; tb_wr[1] = 1'b1;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clk);
      if (tb_wait[1] === 1'b0) acc = 1'b1;
    end
    @(posedge clk); #1;
    sl_wait = 1'b1; tb_wdata[1] = 32'hE000_0001;
    @(negedge clk);
    checks++;
    if (!acc || grant !== 2'b10) $display("FAIL mid_burst_grant got acc=%b grant=%b exp acc=1 grant=10", acc, grant);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (grant !== 2'b00 || pend !== 3'd0 || s_if.write !== 1'b0)
      $display("FAIL mid_async_clear got grant=%b pend=%0d swrite=%b exp grant=00 pend=0 swrite=0",
               grant, pend, s_if.write);
    else passed++;
    tb_wr[1] = 1'b0; sl_wait = 1'b0;
    rq.delete();
    exp_seq = rd_seq;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    sl_rdv = 1'b1; sl_rdata = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    sl_rdv = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b1) $display("FAIL mid_late_rdv_err got=%b exp=1", err); else passed++;
    @(posedge clk); #1;
    push_w(2'b01, 16'h0900, 32'hF000_0000, 4'd1);
    push_w(2'b10, 16'h0A00, 32'hF100_0000, 4'd1);
    fork
      do_cmd(1, 1'b1, 16'h0A00, 32'hF100_0000, 4'd1);
      do_cmd(0, 1'b1, 16'h0900, 32'hF000_0000, 4'd1);
    join
  endtask

  initial begin
    fork
      monitor_loop();
    join_none
    test_reset();
    test_simultaneous_writes();
    test_write_burst();
    test_read_routing();
    test_fifo_full();
    test_spurious_rdv();
    test_reset_mid_burst();
    repeat (3) @(negedge clk);
    checks++;
    if (wq.size() != 0 || rq.size() != 0)
      $display("FAIL scoreboard_leftover got wq=%0d rq=%0d exp wq=0 rq=0", wq.size(), rq.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "simulation time limit reached");
  end
endmodule
